// File: rtl/prio_rr_encoder.sv
// N-input priority encoder with a registered valid/ready output and a runtime fixed/round-robin mode.
// Optional one-hot grant output enabled by defining PRIO_RR_ONEHOT_EN.
module prio_rr_encoder #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
`ifdef PRIO_RR_ONEHOT_EN
    output logic [N-1:0] grant_oh,
`endif
    output logic         out_valid,
    output logic [W-1:0] code
);

    localparam int             DW      = $clog2(2 * N);
    localparam logic [W-1:0]   PTR_TOP = W'(N - 1);
    localparam logic [DW-1:0]  N_DW    = DW'(N);

    logic [W-1:0]     r_ptr;
    logic [W-1:0]     r_code;
    logic             r_valid;

    logic             w_any;
    logic             w_cap;
    logic [W-1:0]     w_ptr_eff;
    logic [2*N-1:0]   w_double;
    logic [2*N-1:0]   w_window;
    logic [DW-1:0]    w_hit;
    logic [W-1:0]     w_winner;
    logic [W-1:0]     w_ptr_next;

    assign w_any    = |req;
    assign w_cap    = w_any && (!r_valid || out_ready);
    assign w_double = {req, req};

    // Fixed priority is round-robin with the pointer pinned at the top index.
    assign w_ptr_eff = mode ? r_ptr : PTR_TOP;

    // The window (ptr, ptr+N] of the doubled vector holds each request bit once,
    // ordered so that its highest set bit is the first hit of the wrapped downward scan.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_window = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (i > int'(w_ptr_eff) && i <= int'(w_ptr_eff) + N) begin
                w_window[i] = w_double[i];
            end
        end
    end

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (w_window[i]) begin
                w_hit = DW'(i);
            end
        end
    end

    always_comb begin
        w_winner = '0;
        if (w_hit >= N_DW) begin
            w_winner = W'(w_hit - N_DW);
        end else begin
            w_winner = W'(w_hit);
        end
    end

    // The granted source drops to lowest priority for the next round-robin grant.
    assign w_ptr_next = (w_winner == '0) ? PTR_TOP : (w_winner - W'(1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_ptr   <= PTR_TOP;
        end else if (w_cap) begin
            r_valid <= 1'b1;
            r_code  <= w_winner;
            if (mode) begin
                r_ptr <= w_ptr_next;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign code      = r_code;

`ifdef PRIO_RR_ONEHOT_EN
    logic [N-1:0] r_grant_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_oh <= '0;
        end else if (w_cap) begin
            r_grant_oh <= N'(1) << w_winner;
        end else if (r_valid && out_ready) begin
            r_grant_oh <= '0;
        end
    end

    assign grant_oh = r_grant_oh;
`endif

endmodule

// File: doc/prio_rr_encoder.md
Name: prio_rr_encoder

Overview:
- Parametrised N-input priority encoder with a registered output and a valid/ready handshake.
- Adds a runtime-selectable round-robin mode, so repeated requests from several sources are serviced fairly rather than the highest index always winning.
- Sits between request-generating blocks (interrupt lines, channel request vectors) and a single consumer that accepts one encoded index per transfer.

Parameters:
- N, 8, number of request lines; legal range N >= 2.
- W, $clog2(N), width of the encoded index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i set = source i requesting.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- out_ready  input  1  consumer accepts the output this cycle.
- out_valid  output  1  code holds a valid winner.
- code  output  W  index of the granted request.

Behaviour:
- Reset, synchronous, while rst=1 at a rising edge:
  - out_valid=0, code=0, round-robin pointer ptr=N-1.
  - rst has priority over every other event, including a stalled valid output, which is discarded.
- Capture condition: cap = (req != 0) && (!out_valid || out_ready).
  - On cap: code <= winner, out_valid <= 1. Latency from req to out_valid/code is 1 cycle.
  - Not cap and out_valid && out_ready: out_valid <= 0; code holds its last value.
  - Not cap otherwise: out_valid and code hold.
- Stall: while out_valid=1 && out_ready=0, code is frozen and req is ignored (not sampled). A request that is deasserted during a stall is lost; that is intended.
- Back-to-back: when the output is consumed and req != 0 in the same cycle, a new winner is captured and out_valid stays 1. Throughput is one grant per cycle.
- Fixed mode (mode=0):
  - winner = highest set index in req.
  - ptr is not modified.
- Round-robin mode (mode=1):
  - Scan starts at index ptr and proceeds downward with wrap: ptr, ptr-1, ..., 0, N-1, ..., ptr+1. The first set bit wins.
  - On capture of winner g: ptr <= (g == 0) ? N-1 : g-1.
  - The granted source therefore has lowest priority on the next grant.
- Mode is sampled only on capture cycles. Switching mode does not reset ptr; round-robin resumes from the stored pointer.
- After reset, ptr=N-1, so the first round-robin grant equals the fixed-priority grant.
- req = 0: no capture and ptr is unchanged; code is don't-care to the consumer when out_valid=0, but is held.
- Single-request vectors: both modes return that index.
- Implementation:
  - Winner selection is combinational from req, ptr and mode.
  - Use a doubled-vector or rotate-and-encode structure; must be width-generic, with no per-N case statements.

Optional Feature:
- Macro: PRIO_RR_ONEHOT_EN.
- Defined:
  - Adds output port grant_oh [N-1:0], a registered one-hot copy of code (bit code set).
  - grant_oh is updated on the same capture edge as code and cleared to 0 on reset.
  - grant_oh reads 0 whenever out_valid is 0 (cleared on the consume-without-capture edge).
- Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- All cases use N=8.
- Reset with req=8'h00 for 3 cycles -> out_valid=0, code=0 throughout; grant_oh=0 when the feature is enabled.
- mode=0, out_ready=1, req=8'b0010_0110 for one cycle -> next cycle out_valid=1, code=5; following cycle out_valid=0.
- mode=1, out_ready=1, req=8'hFF held -> codes 7,6,5,4,3,2,1,0,7 on consecutive cycles, out_valid continuously 1.
- mode=1, out_ready=1, req=8'b1000_0001 held -> codes alternate 7,0,7,0; with mode=0 the same stimulus gives 7 every cycle.
- Backpressure:
  - Capture code=3 (req=8'h08), then out_ready=0 and req=8'h80 for 4 cycles -> code stays 3, out_valid=1.
  - Then out_ready=1 -> next cycle code=7.
- Reset mid-stall:
  - mode=1, out_valid=1, out_ready=0, ptr advanced; assert rst for 1 cycle -> out_valid=0 next cycle.
  - Then req=8'hFF, out_ready=1 -> first code=7, confirming ptr returned to N-1.
